instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the datapath immediate generator: packs opcode/register fields plus a 64-bit sign-extended immediate into a 32-bit RV instruction word, placing each immediate bit where the generator reads it back.
- Streams encoded words, with byte addresses, to instruction-memory write logic.
- Used by the test-program loader so benches build programs from fields, not hand-made hex.
- Supports a `li` pseudo-op that expands to one or two words.

Parameters:
OPERAND_LENGTH, 63, MSB index of the immediate input (width OPERAND_LENGTH+1).
ADDR_W, 32, width of the output byte address.
BASE_ADDR, 0, address of the first emitted word after reset/flush.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
flush  input  1  synchronous abort; address back to BASE_ADDR
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid&in_ready
in_opcode  input  7  opcode[6:0]
in_rd, in_rs1, in_rs2  input  5 each  register fields
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (R-type only)
in_imm  input  OPERAND_LENGTH+1  sign-extended immediate (byte offset for B)
in_li  input  1  pseudo-op li rd,imm; opcode/rs/funct ignored
out_instr  output  32  encoded word
out_addr  output  ADDR_W  byte address of out_instr
out_valid  output  1  word valid
out_ready  input  1  consumer takes word when out_valid&out_ready
err  output  1  one-cycle pulse: request rejected
err_code  output  2  1=imm out of range, 2=bad alignment, 3=unsupported opcode; held until next err
word_count  output  16  words accepted by consumer since reset/flush

Behaviour:
- Reset/flush (reset has priority): state IDLE, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_code=0, word_count=0. A pending word is dropped.
- FSM states IDLE, EMIT, EMIT_LO.
- in_ready = (state==IDLE) | (state==EMIT & out_valid & out_ready & no second word pending). Back-to-back throughput is one word/cycle.
- Encoding is registered: latency 1 cycle from accept to out_valid.
- I (0000011, 0010011): imm[11:0] -> [31:20].
- S (0100011): imm[11:5] -> [31:25]; imm[4:0] -> [11:7].
- B (1100011): imm[12] -> 31; imm[10:5] -> [30:25]; imm[4:1] -> [11:8]; imm[11] -> 7.
- U (0110111, 0010111): imm[31:12] -> [31:12].
- R (0110011): funct7 -> [31:25]; imm ignored.
- rd -> [11:7]; funct3 -> [14:12]; rs1 -> [19:15]; rs2 -> [24:20]; fields not used by the format are zero.
- Range checks, applied on accept:
  - I/S: in_imm equals sign-extension of its bits [11:0].
  - B: in_imm[0]=0 (else code 2) and sign-extension of bits [12:0].
  - U: in_imm[11:0]=0 (else code 2) and sign-extension of bits [31:0].
  - Any other opcode: code 3.
- Rejected request: consumed (in_ready was 1); nothing emitted; err=1 for the cycle after accept; out_addr unchanged.
- li (in_li=1):
  - imm fits 12-bit signed: one word, ADDI rd,x0,imm.
  - Else requires -2^31 <= imm <= 0x7FFFF7FF (else code 1). Emits LUI rd,hi then ADDI rd,rd,lo, with lo=imm[11:0] and hi=(imm+0x800)[31:12].
  - State goes EMIT -> EMIT_LO. in_ready=0 until the second word is accepted by the consumer.
- Output stability: while out_valid & !out_ready, out_instr and out_addr are held constant.
- On each consumer accept: out_addr += 4, wrapping modulo 2^ADDR_W; word_count += 1, saturating at 0xFFFF.
- flush asserted in the same cycle as an in_valid/out accept: flush wins; the request is not accepted and the count does not change.

Test Plan:
- addi: opcode 0010011, rd=1, rs1=0, funct3=0, imm=5, out_ready=1 -> next cycle out_instr=0x00500093, out_addr=0x0. Following accept gives out_addr=0x4, word_count=1.
- sw x2,8(x3): opcode 0100011, funct3=2, rs1=3, rs2=2, imm=8 -> 0x0021A423. beq x1,x2,-4 (funct3=0) -> 0xFE208EE3.
- li x5,0x12345678 -> 0x123452B7 at addr A, then 0x67828293 at A+4. in_ready=0 until the second word is taken. li x5,-1 -> single word 0xFFF00293.
- Errors:
  - addi imm=2048 -> err pulse, err_code=1, no out_valid, out_addr unchanged.
  - beq imm=3 -> err_code=2.
  - opcode 1111111 -> err_code=3.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_instr/out_addr stable and in_ready=0. Release -> one word/cycle thereafter.
- Mid-operation: assert reset, then flush, during EMIT_LO -> out_valid=0 next cycle, out_addr=BASE_ADDR, word_count=0, second li word never appears.

Source files
------------

// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
//   Bundles the request side, the encoded-word stream and the status outputs
//   of instr_encoder. The clock and reset stay plain ports on the module.
//
//   Request side  : flush, in_valid/in_ready handshake, in_opcode, in_rd,
//                   in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_li
//   Stream side   : out_instr, out_addr, out_valid/out_ready handshake
//   Status        : err (one-cycle pulse), err_code (held), word_count
//
//   master : the program loader / bench (drives requests, takes words)
//   slave  : the encoder itself
// ----------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int OPERAND_LENGTH = 63,
    parameter int ADDR_W         = 32
);
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [6:0]              in_opcode;
    logic [4:0]              in_rd;
    logic [4:0]              in_rs1;
    logic [4:0]              in_rs2;
    logic [2:0]              in_funct3;
    logic [6:0]              in_funct7;
    logic [OPERAND_LENGTH:0] in_imm;
    logic                    in_li;
    logic [31:0]             out_instr;
    logic [ADDR_W-1:0]       out_addr;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err;
    logic [1:0]              err_code;
    logic [15:0]             word_count;

    modport master (
        output flush, in_valid, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, in_li, out_ready,
        input  in_ready, out_instr, out_addr, out_valid,
               err, err_code, word_count
    );

    modport slave (
        input  flush, in_valid, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, in_li, out_ready,
        output in_ready, out_instr, out_addr, out_valid,
               err, err_code, word_count
    );
endinterface

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   Packs opcode/register fields and a sign-extended immediate into a 32-bit
//   RV instruction word (the inverse of the datapath immediate generator) and
//   streams the words, tagged with byte addresses, to instruction-memory
//   write logic. A "li rd,imm" pseudo-op expands to ADDI, or LUI+ADDI.
//
//   Ports
//     clk   : clock, everything on the rising edge
//     reset : synchronous, active-high; higher priority than bus.flush
//     bus   : instr_encoder_if.slave (request, word stream, status)
//
//   Timing
//     One cycle from request accept to out_valid. A word whose consumer
//     accepts it in the same cycle a new request arrives is replaced at once,
//     giving one word per cycle. Rejected requests are consumed, raise err
//     for one cycle and emit nothing.
//
//   The immediate must be at least 32 bits wide (OPERAND_LENGTH >= 31) for
//   the U-type and li range checks to be meaningful.
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter int                OPERAND_LENGTH = 63,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0
) (
    input  logic                clk,
    input  logic                reset,
    instr_encoder_if.slave      bus
);

    localparam int IMM_W = OPERAND_LENGTH + 1;

    // Opcodes understood by the encoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_OPC   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EMIT    = 2'd1,
        S_EMIT_LO = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_valid;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic [15:0]       r_word_count;
    logic [31:0]       r_lo_instr;   // ADDI half of a two-word li
    logic              r_lo_pending; // current word is the LUI half of a li

    // ------------------------------------------------------------------------
    // Immediate range helpers
    // ------------------------------------------------------------------------
    // True when v equals the sign-extension of its low n bits: after an
    // arithmetic shift by n-1 only copies of the sign bit may remain.
    function automatic logic fits_signed(input logic [IMM_W-1:0] v, input int n);
        logic signed [IMM_W-1:0] sh;
        sh = $signed(v) >>> (n - 1);
        return (sh == '0) || (sh == '1);
    endfunction

    logic [IMM_W-1:0] w_imm;
    logic             w_fit12;
    logic             w_fit13;
    logic             w_fit32;
    logic             w_li_gap;
    logic [31:0]      w_li_sum;

    assign w_imm   = bus.in_imm;
    assign w_fit12 = fits_signed(w_imm, 12);
    assign w_fit13 = fits_signed(w_imm, 13);
    assign w_fit32 = fits_signed(w_imm, 32);

    // 0x7FFFF800..0x7FFFFFFF fit in 32 bits but the +0x800 rounding of the
    // upper part would overflow into bit 31, so LUI+ADDI cannot build them.
    assign w_li_gap = (w_imm[31:11] == 21'h0F_FFFF);

    // ADDI sign-extends its 12-bit lo, so the upper part is rounded up
    // whenever lo is negative.
    assign w_li_sum = w_imm[31:0] + 32'h0000_0800;

    // ------------------------------------------------------------------------
    // Combinational encode of the request currently on the bus
    // ------------------------------------------------------------------------
    logic [31:0] w_word0;
    logic [31:0] w_word1;
    logic        w_two;
    logic [1:0]  w_code;

    always_comb begin
        w_word0 = '0;
        w_word1 = '0;
        w_two   = 1'b0;
        w_code  = ERR_NONE;

        if (bus.in_li) begin
            if (w_fit12) begin
                // ADDI rd, x0, imm
                w_word0 = {w_imm[11:0], 5'd0, 3'b000, bus.in_rd, OP_IMM};
            end else if (w_fit32 && !w_li_gap) begin
                // LUI rd, hi ; ADDI rd, rd, lo
                w_word0 = {w_li_sum[31:12], bus.in_rd, OP_LUI};
                w_word1 = {w_imm[11:0], bus.in_rd, 3'b000, bus.in_rd, OP_IMM};
                w_two   = 1'b1;
            end else begin
                w_code = ERR_RANGE;
            end
        end else begin
            case (bus.in_opcode)
                OP_LOAD, OP_IMM: begin
                    w_word0 = {w_imm[11:0], bus.in_rs1, bus.in_funct3,
                               bus.in_rd, bus.in_opcode};
                    if (!w_fit12) begin
                        w_code = ERR_RANGE;
                    end
                end
                OP_STORE: begin
                    w_word0 = {w_imm[11:5], bus.in_rs2, bus.in_rs1,
                               bus.in_funct3, w_imm[4:0], bus.in_opcode};
                    if (!w_fit12) begin
                        w_code = ERR_RANGE;
                    end
                end
                OP_BRANCH: begin
                    // Branch offsets are even; bit 0 is never encoded.
                    w_word0 = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1,
                               bus.in_funct3, w_imm[4:1], w_imm[11], bus.in_opcode};
                    if (w_imm[0]) begin
                        w_code = ERR_ALIGN;
                    end else if (!w_fit13) begin
                        w_code = ERR_RANGE;
                    end
                end
                OP_LUI, OP_AUIPC: begin
                    w_word0 = {w_imm[31:12], bus.in_rd, bus.in_opcode};
                    if (w_imm[11:0] != 12'd0) begin
                        w_code = ERR_ALIGN;
                    end else if (!w_fit32) begin
                        w_code = ERR_RANGE;
                    end
                end
                OP_OP: begin
                    w_word0 = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                               bus.in_funct3, bus.in_rd, bus.in_opcode};
                end
                default: begin
                    w_code = ERR_OPC;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    logic w_out_fire;
    logic w_in_ready;
    logic w_in_fire;

    assign w_out_fire = r_out_valid & bus.out_ready;

    // A new request may overlap the consumer taking the current word, unless
    // that word is the first half of a li. Reset and flush block acceptance.
    assign w_in_ready = !reset && !bus.flush &&
                        ((r_state == S_IDLE) ||
                         ((r_state == S_EMIT) && w_out_fire && !r_lo_pending));

    assign w_in_fire = bus.in_valid & w_in_ready;

    // ------------------------------------------------------------------------
    // FSM and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_state      <= S_IDLE;
            r_out_instr  <= '0;
            r_out_addr   <= BASE_ADDR;
            r_out_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_word_count <= '0;
            r_lo_instr   <= '0;
            r_lo_pending <= 1'b0;
        end else begin
            r_err <= 1'b0;

            if (w_out_fire) begin
                r_out_addr <= r_out_addr + ADDR_W'(4);
                if (r_word_count != 16'hFFFF) begin
                    r_word_count <= r_word_count + 16'd1;
                end
            end

            // A word is loaded into the output register only from an accepted,
            // error-free request; in IDLE and on a back-to-back accept in EMIT
            // the loading is identical, so it is shared here.
            if (w_in_fire) begin
                if (w_code != ERR_NONE) begin
                    r_err        <= 1'b1;
                    r_err_code   <= w_code;
                    r_out_valid  <= 1'b0;
                    r_lo_pending <= 1'b0;
                    r_state      <= S_IDLE;
                end else begin
                    r_out_instr  <= w_word0;
                    r_lo_instr   <= w_word1;
                    r_lo_pending <= w_two;
                    r_out_valid  <= 1'b1;
                    r_state      <= S_EMIT;
                end
            end else begin
                case (r_state)
                    S_EMIT: begin
                        if (w_out_fire) begin
                            if (r_lo_pending) begin
                                r_out_instr  <= r_lo_instr;
                                r_lo_pending <= 1'b0;
                                r_state      <= S_EMIT_LO;
                            end else begin
                                r_out_valid <= 1'b0;
                                r_state     <= S_IDLE;
                            end
                        end
                    end
                    S_EMIT_LO: begin
                        if (w_out_fire) begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_instr  = r_out_instr;
    assign bus.out_addr   = r_out_addr;
    assign bus.out_valid  = r_out_valid;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;
    assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//   Table-driven vectors for the encoder plus hand-written sequences for
//   backpressure, back-to-back throughput, and reset/flush during a li.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_encoder_if #(.OPERAND_LENGTH(63), .ADDR_W(32)) bus ();

    instr_encoder #(
        .OPERAND_LENGTH(63),
        .ADDR_W        (32),
        .BASE_ADDR     (32'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        li;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [1:0]  ecode;
        logic        two;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_addr = 32'h0;
    int          exp_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.in_li     = v.li;
        bus.in_opcode = v.op;
        bus.in_rd     = v.rd;
        bus.in_rs1    = v.rs1;
        bus.in_rs2    = v.rs2;
        bus.in_funct3 = v.f3;
        bus.in_funct7 = v.f7;
        bus.in_imm    = v.imm;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        chk(name, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 7'h13, 5'd1,  5'd0, 5'd7, 3'd0, 7'h7F, 64'd5,                   2'd0, 1'b0, 32'h00500093, 32'h0};
        vecs[1]  = '{1'b0, 7'h23, 5'd31, 5'd3, 5'd2, 3'd2, 7'h00, 64'd8,                   2'd0, 1'b0, 32'h0021A423, 32'h0};
        vecs[2]  = '{1'b0, 7'h63, 5'd9,  5'd1, 5'd2, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFC, 2'd0, 1'b0, 32'hFE208EE3, 32'h0};
        vecs[3]  = '{1'b1, 7'h7F, 5'd5,  5'd9, 5'd9, 3'd7, 7'h7F, 64'h0000_0000_1234_5678, 2'd0, 1'b1, 32'h123452B7, 32'h67828293};
        vecs[4]  = '{1'b1, 7'h00, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0, 32'hFFF00293, 32'h0};
        vecs[5]  = '{1'b0, 7'h37, 5'd7,  5'd3, 5'd0, 3'd0, 7'h00, 64'h0000_0000_1234_5000, 2'd0, 1'b0, 32'h123453B7, 32'h0};
        vecs[6]  = '{1'b0, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 64'h123,                 2'd0, 1'b0, 32'h002081B3, 32'h0};
        vecs[7]  = '{1'b0, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'h20, 64'h0,                   2'd0, 1'b0, 32'h402081B3, 32'h0};
        vecs[8]  = '{1'b0, 7'h03, 5'd6,  5'd2, 5'd0, 3'd2, 7'h00, 64'hFFFF_FFFF_FFFF_FFF8, 2'd0, 1'b0, 32'hFF812303, 32'h0};
        vecs[9]  = '{1'b0, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_F800, 2'd0, 1'b0, 32'h80000093, 32'h0};
        vecs[10] = '{1'b0, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 64'd2048,                2'd1, 1'b0, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 64'd3,                   2'd2, 1'b0, 32'h0, 32'h0};
        vecs[12] = '{1'b0, 7'h7F, 5'd1,  5'd1, 5'd1, 3'd0, 7'h00, 64'd0,                   2'd3, 1'b0, 32'h0, 32'h0};
        vecs[13] = '{1'b1, 7'h00, 5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_7FFF_F800, 2'd1, 1'b0, 32'h0, 32'h0};
        vecs[14] = '{1'b0, 7'h37, 5'd7,  5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_1234_5001, 2'd2, 1'b0, 32'h0, 32'h0};
        vecs[15] = '{1'b1, 7'h00, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_7FFF_F7FF, 2'd0, 1'b1, 32'h7FFFF0B7, 32'h7FF08093};
        vecs[16] = '{1'b1, 7'h00, 5'd2,  5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_0000_0800, 2'd0, 1'b1, 32'h00001137, 32'h80010113};
        vecs[17] = '{1'b1, 7'h00, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_8000_0000, 2'd0, 1'b1, 32'h800000B7, 32'h00008093};
        vecs[18] = '{1'b1, 7'h00, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_7FFF_FFFF, 2'd1, 1'b0, 32'h0, 32'h0};
        vecs[19] = '{1'b0, 7'h37, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0001_0000_0000, 2'd1, 1'b0, 32'h0, 32'h0};
        vecs[20] = '{1'b0, 7'h17, 5'd4,  5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_F000, 2'd0, 1'b0, 32'hFFFFF217, 32'h0};
        vecs[21] = '{1'b0, 7'h63, 5'd0,  5'd3, 5'd4, 3'd1, 7'h00, 64'd2048,                2'd0, 1'b0, 32'h004190E3, 32'h0};
        vecs[22] = '{1'b0, 7'h63, 5'd0,  5'd3, 5'd4, 3'd0, 7'h00, 64'd4096,                2'd1, 1'b0, 32'h0, 32'h0};
        vecs[23] = '{1'b0, 7'h23, 5'd0,  5'd6, 5'd5, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0, 32'hFE530FA3, 32'h0};

        // ---------------- reset state ----------------
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(vecs[0]);
        repeat (3) step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
        chk("rst_out_addr",  64'(bus.out_addr),  64'd0);
        chk("rst_err",       64'(bus.err),       64'd0);
        chk("rst_err_code",  64'(bus.err_code),  64'd0);
        chk("rst_count",     64'(bus.word_count), 64'd0);
        reset = 1'b0;
        step();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            wait_ready($sformatf("v%0d_in_ready", i));
            drive(vecs[i]);
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            if (vecs[i].ecode != 2'd0) begin
                chk($sformatf("v%0d_err", i),       64'(bus.err),       64'd1);
                chk($sformatf("v%0d_err_code", i),  64'(bus.err_code),  64'(vecs[i].ecode));
                chk($sformatf("v%0d_no_valid", i),  64'(bus.out_valid), 64'd0);
                chk($sformatf("v%0d_addr_hold", i), 64'(bus.out_addr),  64'(exp_addr));
                step();
                chk($sformatf("v%0d_err_pulse", i), 64'(bus.err),       64'd0);
                chk($sformatf("v%0d_code_held", i), 64'(bus.err_code),  64'(vecs[i].ecode));
            end else begin
                chk($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'd1);
                chk($sformatf("v%0d_instr", i), 64'(bus.out_instr), 64'(vecs[i].w0));
                chk($sformatf("v%0d_addr", i),  64'(bus.out_addr),  64'(exp_addr));
                chk($sformatf("v%0d_noerr", i), 64'(bus.err),       64'd0);
                step();
                exp_addr += 32'd4;
                exp_count++;
                if (vecs[i].two) begin
                    chk($sformatf("v%0d_valid_lo", i),   64'(bus.out_valid), 64'd1);
                    chk($sformatf("v%0d_instr_lo", i),   64'(bus.out_instr), 64'(vecs[i].w1));
                    chk($sformatf("v%0d_addr_lo", i),    64'(bus.out_addr),  64'(exp_addr));
                    chk($sformatf("v%0d_ready_lo", i),   64'(bus.in_ready),  64'd0);
                    step();
                    exp_addr += 32'd4;
                    exp_count++;
                end
                chk($sformatf("v%0d_done", i),  64'(bus.out_valid),  64'd0);
                chk($sformatf("v%0d_count", i), 64'(bus.word_count), 64'(exp_count));
            end
        end

        // ---------------- backpressure then back-to-back ----------------
        bus.out_ready = 1'b0;
        drive(vecs[0]);
        bus.in_valid = 1'b1;
        step();
        drive(vecs[6]);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_in_ready", k), 64'(bus.in_ready),  64'd0);
            chk($sformatf("bp%0d_valid", k),    64'(bus.out_valid), 64'd1);
            chk($sformatf("bp%0d_instr", k),    64'(bus.out_instr), 64'h00500093);
            chk($sformatf("bp%0d_addr", k),     64'(bus.out_addr),  64'(exp_addr));
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        step();
        exp_addr += 32'd4;
        exp_count++;
        chk("b2b_1_instr", 64'(bus.out_instr), 64'h002081B3);
        chk("b2b_1_addr",  64'(bus.out_addr),  64'(exp_addr));
        chk("b2b_1_ready", 64'(bus.in_ready),  64'd1);
        drive(vecs[7]);
        step();
        exp_addr += 32'd4;
        exp_count++;
        chk("b2b_2_instr", 64'(bus.out_instr), 64'h402081B3);
        chk("b2b_2_addr",  64'(bus.out_addr),  64'(exp_addr));
        bus.in_valid = 1'b0;
        step();
        exp_addr += 32'd4;
        exp_count++;
        chk("b2b_done",  64'(bus.out_valid),  64'd0);
        chk("b2b_count", 64'(bus.word_count), 64'(exp_count));

        // ---------------- reset during EMIT_LO ----------------
        wait_ready("mr_ready");
        drive(vecs[3]);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("mr_lui", 64'(bus.out_instr), 64'h123452B7);
        step();
        chk("mr_addi", 64'(bus.out_instr), 64'h67828293);
        bus.out_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        exp_addr  = 32'h0;
        exp_count = 0;
        chk("mr_valid", 64'(bus.out_valid),  64'd0);
        chk("mr_addr",  64'(bus.out_addr),   64'd0);
        chk("mr_count", 64'(bus.word_count), 64'd0);
        step();
        chk("mr_no_lo", 64'(bus.out_valid), 64'd0);

        // ---------------- flush during EMIT_LO (with consumer accepting) ----
        drive(vecs[3]);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("mf_addi",  64'(bus.out_instr),  64'h67828293);
        chk("mf_addr1", 64'(bus.out_addr),   64'd4);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("mf_valid", 64'(bus.out_valid),  64'd0);
        chk("mf_addr",  64'(bus.out_addr),   64'd0);
        chk("mf_count", 64'(bus.word_count), 64'd0);
        step();
        chk("mf_no_lo", 64'(bus.out_valid), 64'd0);

        // ---------------- flush beats a simultaneous request ----------------
        drive(vecs[0]);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        #1;
        chk("fw_ready", 64'(bus.in_ready), 64'd0);
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("fw_valid", 64'(bus.out_valid),  64'd0);
        chk("fw_err",   64'(bus.err),        64'd0);
        chk("fw_count", 64'(bus.word_count), 64'd0);
        step();
        chk("fw_still_idle", 64'(bus.out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
